// File: rtl/pc_sequencer.sv
// pc_sequencer: MiniMIPS program-counter owner; fetch/execute/update sequencing with halt/jump/branch priority and retired-instruction count.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        halt,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, EXECUTE, UPDATE, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, next_pc_q, next_pc_d, count_q, count_d;
  logic [31:0] pc_plus, jump_pc, branch_pc;
  assign pc_plus   = pc_q + 32'(PC_STEP);
  assign jump_pc   = {pc_plus[31:28], jump_target, 2'b00};
  assign branch_pc = pc_plus + (branch_offset << 2);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = imem_ready ? EXECUTE : FETCH;
      EXECUTE: if (!stall) begin
        state_d   = halt ? HALT : UPDATE;
        next_pc_d = jump ? jump_pc : (branch && zero) ? branch_pc : pc_plus;
      end
      UPDATE: begin
        state_d = FETCH;
        pc_d    = next_pc_q;
        count_d = count_q + 32'd1;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      next_pc_q <= 32'd0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      count_q   <= count_d;
    end
  end
  // Handshake outputs decode the state directly so reset clears them without waiting for a clock.
  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign instr_valid = state_q == EXECUTE;
  assign halted      = state_q == HALT;
  assign pc          = pc_q;
  assign state       = state_q;
  assign instr_count = count_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the pc_sequencer FSM, next-PC priority, handshakes and async reset.
module tb_pc_sequencer;
  logic        clock = 0, reset = 1;
  logic        imem_ready = 0, branch = 0, zero = 0, jump = 0, halt = 0, stall = 0;
  logic [31:0] branch_offset = 0;
  logic [25:0] jump_target = 0;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, pc, instr_count;
  logic [2:0]  state;
  logic        j1 = 0, b1 = 0, z1 = 0;
  logic [25:0] tgt1 = 0;
  logic [31:0] off1 = 0;
  logic        req1, valid1, halted1, req2, valid2, halted2;
  logic [31:0] addr1, pc1, cnt1, addr2, pc2, cnt2;
  logic [2:0]  st1, st2;
  int checks = 0, errors = 0;
  logic [31:0] exp_count = 0;
  always #5 clock = ~clock;
  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .instr_valid(instr_valid), .branch(branch), .zero(zero),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target), .halt(halt),
    .stall(stall), .pc(pc), .state(state), .halted(halted), .instr_count(instr_count));
  pc_sequencer #(.RESET_PC(32'h1000_0010)) dut1 (
    .clock(clock), .reset(reset), .imem_req(req1), .imem_addr(addr1),
    .imem_ready(imem_ready), .instr_valid(valid1), .branch(b1), .zero(z1),
    .branch_offset(off1), .jump(j1), .jump_target(tgt1), .halt(1'b0),
    .stall(stall), .pc(pc1), .state(st1), .halted(halted1), .instr_count(cnt1));
  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(imem_ready), .instr_valid(valid2), .branch(1'b0), .zero(1'b0),
    .branch_offset(32'd0), .jump(1'b0), .jump_target(26'd0), .halt(1'b0),
    .stall(stall), .pc(pc2), .state(st2), .halted(halted2), .instr_count(cnt2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic run_instr(input logic [31:0] exp_pc);
    step();
    chk("exec_state", 32'(state), 32'd2);
    chk("exec_valid", 32'(instr_valid), 32'd1);
    step();
    chk("update_state", 32'(state), 32'd3);
    step();
    exp_count++;
    chk("fetch_state", 32'(state), 32'd1);
    chk("pc", pc, exp_pc);
    chk("imem_addr", imem_addr, exp_pc);
    chk("instr_count", instr_count, exp_count);
  endtask
  initial begin
    #1 reset = 0;
    #11;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_pc1", pc1, 32'h1000_0010);
    chk("rst_pc2", pc2, 32'hFFFF_FFFC);
    reset = 1;
    imem_ready = 1;
    j1 = 1; tgt1 = 26'h40; b1 = 1; z1 = 1; off1 = 32'd5;
    step();
    chk("first_fetch_state", 32'(state), 32'd1);
    chk("first_fetch_req", 32'(imem_req), 32'd1);
    chk("first_fetch_addr", imem_addr, 32'd0);
    chk("first_fetch_addr1", addr1, 32'h1000_0010);
    run_instr(32'd4);
    chk("jump_wins_pc1", pc1, 32'h1000_0100);
    chk("wrap_pc2", pc2, 32'd0);
    j1 = 0; b1 = 0; z1 = 0;
    run_instr(32'd8);
    branch = 1; zero = 1; branch_offset = 32'd3;
    run_instr(32'd24);
    branch_offset = 32'hFFFF_FFFA;
    run_instr(32'd4);
    branch = 0; zero = 0;
    run_instr(32'd8);
    branch = 1; zero = 0; branch_offset = 32'd3;
    run_instr(32'd12);
    branch = 0;
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_state", 32'(state), 32'd1);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, 32'd12);
      step();
    end
    chk("wait4_req", 32'(imem_req), 32'd1);
    chk("wait4_addr", imem_addr, 32'd12);
    imem_ready = 1;
    step();
    chk("after_wait_state", 32'(state), 32'd2);
    imem_ready = 0;
    stall = 1; branch = 1; zero = 1; branch_offset = 32'd100;
    chk("stall_valid1", 32'(instr_valid), 32'd1);
    step();
    chk("stall_valid2", 32'(instr_valid), 32'd1);
    chk("stall_state2", 32'(state), 32'd2);
    step();
    chk("stall_valid3", 32'(instr_valid), 32'd1);
    chk("stall_state3", 32'(state), 32'd2);
    stall = 0; branch = 0; zero = 0;
    step();
    chk("post_stall_state", 32'(state), 32'd3);
    step();
    exp_count++;
    chk("post_stall_pc", pc, 32'd16);
    chk("post_stall_count", instr_count, exp_count);
    step();
    chk("fetch_hold_state", 32'(state), 32'd1);
    chk("fetch_hold_addr", imem_addr, 32'd16);
    #2 reset = 0;
    #1;
    exp_count = 0;
    chk("midfetch_rst_state", 32'(state), 32'd0);
    chk("midfetch_rst_pc", pc, 32'd0);
    chk("midfetch_rst_req", 32'(imem_req), 32'd0);
    chk("midfetch_rst_count", instr_count, 32'd0);
    step();
    chk("rst_held_state", 32'(state), 32'd0);
    #2 reset = 1;
    #1;
    chk("idle_after_release", 32'(state), 32'd0);
    imem_ready = 1;
    step();
    chk("refetch_state", 32'(state), 32'd1);
    chk("refetch_addr", imem_addr, 32'd0);
    run_instr(32'd4);
    halt = 1; jump = 1; jump_target = 26'd5;
    step();
    chk("halt_exec_state", 32'(state), 32'd2);
    step();
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    halt = 0; jump = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("halt_hold_state", 32'(state), 32'd4);
      chk("halt_hold_pc", pc, 32'd4);
      chk("halt_hold_count", instr_count, 32'd1);
      chk("halt_hold_req", 32'(imem_req), 32'd0);
    end
    #2 reset = 0;
    #1;
    chk("midhalt_rst_state", 32'(state), 32'd0);
    chk("midhalt_rst_halted", 32'(halted), 32'd0);
    chk("midhalt_rst_pc", pc, 32'd0);
    chk("midhalt_rst_count", instr_count, 32'd0);
    step();
    #2 reset = 1;
    #1;
    chk("idle_after_halt_release", 32'(state), 32'd0);
    step();
    chk("fetch_after_halt_state", 32'(state), 32'd1);
    chk("fetch_after_halt_addr", imem_addr, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
